// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types, default geometry and counter helpers for the gshare predictor.
package gshare_branch_predictor_pkg;

  localparam int DEF_DBITS        = 32;
  localparam int DEF_BHR_BITS     = 8;
  localparam int DEF_PT_IDX_BITS  = 8;
  localparam int DEF_BTB_IDX_BITS = 4;

  localparam int PT_ENTRIES  = 1 << DEF_PT_IDX_BITS;
  localparam int BTB_ENTRIES = 1 << DEF_BTB_IDX_BITS;
  localparam int TAG_BITS    = DEF_DBITS - DEF_BTB_IDX_BITS - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bp_state_e;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == ST) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_btb.sv
// Tagged branch target buffer: combinational read, synchronous write and clear.
module bp_btb #(
  parameter int IDX_BITS = 4,
  parameter int TAG_W    = 26,
  parameter int DBITS    = 32
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DBITS-1:0]    rd_target,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [DBITS-1:0]    wr_target,
  input  logic                clr_en,
  input  logic [IDX_BITS-1:0] clr_idx
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic             valid  [ENTRIES];
  logic [TAG_W-1:0] tag    [ENTRIES];
  logic [DBITS-1:0] target [ENTRIES];

  // NOTE: storage arrays carry no reset; the owner clears valid bits one
  // entry per cycle so the arrays can map onto RAM.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
    end
  end

  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tag[rd_idx];
  assign rd_target = target[rd_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with tagged BTB, table-clear FSM and resolution stats.
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int         DBITS        = DEF_DBITS,
  parameter int         BHR_BITS     = DEF_BHR_BITS,
  parameter int         PT_IDX_BITS  = DEF_PT_IDX_BITS,
  parameter int         BTB_IDX_BITS = DEF_BTB_IDX_BITS,
  parameter logic [1:0] PT_INIT      = WNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_req,
  input  logic [DBITS-1:0]       pred_pc,
  output logic                   pred_ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  output logic [DBITS-1:0]       pred_target,
  output logic                   pred_btb_hit,
  output logic [PT_IDX_BITS-1:0] pred_pt_idx,
  input  logic                   upd_valid,
  input  logic [DBITS-1:0]       upd_pc,
  input  logic [PT_IDX_BITS-1:0] upd_pt_idx,
  input  logic                   upd_taken,
  input  logic [DBITS-1:0]       upd_target,
  input  logic                   upd_mispredict,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
);

  localparam int PT_SIZE = 1 << PT_IDX_BITS;
  localparam int TAG_W   = DBITS - BTB_IDX_BITS - 2;

  bp_state_e              state, state_next;
  logic [PT_IDX_BITS-1:0] init_ptr;
  logic [BHR_BITS-1:0]    bhr;
  logic [1:0]             pt [PT_SIZE];

  logic                   ready, pred_fire, upd_fire;
  logic [PT_IDX_BITS-1:0] bhr_ext, pt_idx;
  logic                   btb_valid, btb_hit, taken;
  logic [TAG_W-1:0]       btb_tag;
  logic [DBITS-1:0]       btb_target, target;
  logic                   clr_en;

  assign ready      = (state == READY);
  assign pred_ready = ready;
  assign pred_fire  = ready && pred_req;
  assign upd_fire   = ready && upd_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // NOTE: next-state is assigned a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    if (state == INIT && (&init_ptr)) state_next = READY;
  end

  always_ff @(posedge clk) begin
    if (reset)              init_ptr <= '0;
    else if (state == INIT) init_ptr <= init_ptr + 1'b1;
  end

  // Only the low BTB_ENTRIES indices of the sweep also clear a BTB slot.
  assign clr_en = !reset && state == INIT && ((init_ptr >> BTB_IDX_BITS) == '0);

  always_comb begin
    bhr_ext = '0;
    bhr_ext[BHR_BITS-1:0] = bhr;
  end

  assign pt_idx = pred_pc[PT_IDX_BITS+1:2] ^ bhr_ext;

  bp_btb #(
    .IDX_BITS(BTB_IDX_BITS),
    .TAG_W   (TAG_W),
    .DBITS   (DBITS)
  ) u_btb (
    .clk      (clk),
    .rd_idx   (pred_pc[BTB_IDX_BITS+1:2]),
    .rd_valid (btb_valid),
    .rd_tag   (btb_tag),
    .rd_target(btb_target),
    .wr_en    (!reset && upd_fire && upd_taken),
    .wr_idx   (upd_pc[BTB_IDX_BITS+1:2]),
    .wr_tag   (upd_pc[DBITS-1:BTB_IDX_BITS+2]),
    .wr_target(upd_target),
    .clr_en   (clr_en),
    .clr_idx  (init_ptr[BTB_IDX_BITS-1:0])
  );

  // All reads are combinational from pre-edge state, so a same-cycle update
  // is only visible to the following request.
  assign btb_hit = btb_valid && (btb_tag == pred_pc[DBITS-1:BTB_IDX_BITS+2]);
  assign taken   = btb_hit && pt[pt_idx][1];
  assign target  = taken ? btb_target : pred_pc + DBITS'(4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        pt[init_ptr] <= PT_INIT;
      end else if (upd_valid) begin
        pt[upd_pt_idx] <= upd_taken ? sat_inc2(pt[upd_pt_idx])
                                    : sat_dec2(pt[upd_pt_idx]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bhr              <= '0;
      pred_valid       <= 1'b0;
      pred_taken       <= 1'b0;
      pred_btb_hit     <= 1'b0;
      pred_target      <= '0;
      pred_pt_idx      <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      pred_valid <= pred_fire;
      if (pred_fire) begin
        pred_taken   <= taken;
        pred_btb_hit <= btb_hit;
        pred_target  <= target;
        pred_pt_idx  <= pt_idx;
      end
      if (upd_fire) begin
        bhr <= {bhr[BHR_BITS-2:0], upd_taken};
        if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
        if (upd_mispredict && stat_mispredicts != '1)
          stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor against an array-based reference model.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_ready, pred_valid, pred_taken, pred_btb_hit;
  logic [31:0] pred_target;
  logic [7:0]  pred_pt_idx;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_pt_idx;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  gshare_branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .pred_req        (pred_req),
    .pred_pc         (pred_pc),
    .pred_ready      (pred_ready),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_btb_hit    (pred_btb_hit),
    .pred_pt_idx     (pred_pt_idx),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_pt_idx      (upd_pt_idx),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredict  (upd_mispredict),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        taken;
    logic        hit;
    logic [31:0] target;
    logic [7:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   live  = 1'b0;

  int          pt_m   [256];
  bit          bv_m   [16];
  int unsigned tag_m  [16];
  int unsigned tgt_m  [16];
  int unsigned bhr_m, nbr_m, nmis_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int unsigned m_idx(input int unsigned pc);
    return ((pc >> 2) % 256) ^ bhr_m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) pt_m[i] = 1;
    for (int i = 0; i < 16; i++) bv_m[i] = 1'b0;
    bhr_m = 0; nbr_m = 0; nmis_m = 0;
  endtask

  task automatic step(input bit req, input int unsigned pc, input bit upd,
                      input int unsigned upc, input int unsigned uidx, input bit ut,
                      input int unsigned utgt, input bit umis);
    exp_t        e;
    int unsigned b;
    pred_req = req; pred_pc = pc;
    upd_valid = upd; upd_pc = upc; upd_pt_idx = 8'(uidx);
    upd_taken = ut; upd_target = utgt; upd_mispredict = umis;
    if (req && live) begin
      b        = (pc >> 2) % 16;
      e.idx    = 8'(m_idx(pc));
      e.hit    = bv_m[b] && (tag_m[b] == (pc >> 6));
      e.taken  = e.hit && (pt_m[e.idx] >= 2);
      e.target = e.taken ? tgt_m[b] : pc + 32'd4;
      exp_q.push_back(e);
    end
    if (upd && live) begin
      pt_m[uidx % 256] = ut ? ((pt_m[uidx % 256] == 3) ? 3 : pt_m[uidx % 256] + 1)
                            : ((pt_m[uidx % 256] == 0) ? 0 : pt_m[uidx % 256] - 1);
      bhr_m = ((bhr_m << 1) | int'(ut)) % 256;
      if (ut) begin
        b = (upc >> 2) % 16;
        bv_m[b] = 1'b1; tag_m[b] = upc >> 6; tgt_m[b] = utgt;
      end
      nbr_m++;
      if (umis) nmis_m++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pred(input int unsigned pc);
    step(1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int unsigned pc, input int unsigned idx, input bit t,
                     input int unsigned tgt, input bit mis);
    step(0, 0, 1, pc, idx, t, tgt, mis);
  endtask

  // Eight not-taken resolutions on an unrelated entry return the history to zero.
  task automatic flush_bhr();
    repeat (8) upd(32'h800, 32'h80, 0, 0, 0);
  endtask

  task automatic init_stim();
    pred_req = 1'b1; pred_pc = $urandom;
    upd_valid = 1'($urandom); upd_pc = $urandom; upd_pt_idx = 8'($urandom);
    upd_taken = 1'($urandom); upd_target = $urandom; upd_mispredict = 1'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    live = 1'b0;
    reset = 1'b1;
    pred_req = 1'b0; upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_btb_hit", pred_btb_hit, 0);
    check("rst_pred_target", pred_target, 0);
    check("rst_pred_pt_idx", pred_pt_idx, 0);
    check("rst_stat_branches", stat_branches, 0);
    check("rst_stat_mispredicts", stat_mispredicts, 0);
    check("rst_pred_ready", pred_ready, 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready(input string name);
    int edges = 0;
    for (int i = 0; i < 400; i++) begin
      init_stim();
      edges++;
      if (pred_ready) break;
    end
    check(name, edges, 256);
    pred_req = 1'b0; upd_valid = 1'b0;
    live = 1'b1;
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pred_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pred_valid: got valid=1 pc_idx=0x%0h, expected no response", pred_pt_idx);
        end else begin
          e = exp_q.pop_front();
          check("sb_pred_btb_hit", pred_btb_hit, e.hit);
          check("sb_pred_taken", pred_taken, e.taken);
          check("sb_pred_target", pred_target, e.target);
          check("sb_pred_pt_idx", pred_pt_idx, e.idx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    int unsigned pc, upc;
    model_reset();
    reset = 1'b1; pred_req = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_pt_idx = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    @(posedge clk); #1;

    do_reset();
    wait_ready("init_cycles");
    check("init_stats_untouched", stat_branches, 0);

    pred(32'h1000);
    check("first_pred_target", pred_target, 32'h1004);

    upd(32'h100, 32'h40, 1, 32'h200, 1);
    upd(32'h100, 32'h40, 1, 32'h200, 0);
    flush_bhr();
    pred(32'h100);
    check("trained_hit", pred_btb_hit, 1);
    check("trained_taken", pred_taken, 1);
    check("trained_target", pred_target, 32'h200);

    repeat (4) upd(32'h100, 32'h40, 0, 0, 1);
    pred(32'h100);
    check("sat_low_hit", pred_btb_hit, 1);
    check("sat_low_taken", pred_taken, 0);

    upd(32'h140, 32'h50, 1, 32'h300, 1);
    flush_bhr();
    pred(32'h100);
    check("alias_hit", pred_btb_hit, 0);
    check("alias_target", pred_target, 32'h104);

    upd(32'h100, 32'h40, 1, 32'h200, 0);
    flush_bhr();
    step(1, 32'h100, 1, 32'h100, 32'h40, 1, 32'h200, 0);
    check("rbw_old_taken", pred_taken, 0);
    flush_bhr();
    pred(32'h100);
    check("rbw_new_taken", pred_taken, 1);

    for (int i = 0; i < 400; i++) begin
      pc  = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      upc = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      step(1'($urandom), pc, 1'($urandom), upc,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : m_idx(upc),
           1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom));
    end
    idle();
    idle();
    check("sb_drained", exp_q.size(), 0);
    check("rand_stat_branches", stat_branches, nbr_m);
    check("rand_stat_mispredicts", stat_mispredicts, nmis_m);

    do_reset();
    repeat (100) init_stim();
    check("mid_init_not_ready", pred_ready, 0);
    check("mid_init_stats", stat_branches, 0);
    do_reset();
    wait_ready("reinit_cycles");
    check("reinit_stats", stat_mispredicts, 0);
    pred(32'h100);
    check("reinit_btb_cleared", pred_btb_hit, 0);

    upd(32'h100, 32'h40, 1, 32'h200, 1);
    upd(32'h104, 32'h41, 0, 0, 0);
    upd(32'h108, 32'h42, 1, 32'h400, 0);
    upd(32'h10C, 32'h43, 0, 0, 1);
    upd(32'h110, 32'h44, 1, 32'h500, 0);
    check("stat_branches_5", stat_branches, 5);
    check("stat_mispredicts_2", stat_mispredicts, 2);
    idle();
    idle();
    check("sb_drained_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
